rom_byte_streamer: RTL

- Read-side initiator for the generated synchronous ROMs. It drives rd_en/addr, captures each ROM word, and serialises it into a byte stream with a valid/ready handshake.
- It sits between a ROM instance and byte-oriented consumers such as boot loaders and table-upload engines.
- The ROM has 1-cycle read latency: data_out updates on the clock edge where rd_en is sampled high.
- Byte order within each word is selectable.

---
 rtl/rom_byte_streamer_if.sv | 27 ++
 rtl/rom_byte_streamer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rom_byte_streamer_if.sv
// Bus bundle between the ROM byte streamer, its ROM and its byte consumer.
// master: streamer side (drives ROM read port and byte stream, receives rom_data/out_ready).
// slave : ROM + consumer side (returns rom_data, drives out_ready).
interface rom_byte_streamer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  // ROM read port
  logic                  rom_rd_en;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  // byte stream
  logic [7:0]            out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output rom_rd_en, rom_addr, out_data, out_valid, out_last,
    input  rom_data, out_ready
  );

  modport slave (
    input  rom_rd_en, rom_addr, out_data, out_valid, out_last,
    output rom_data, out_ready
  );
endinterface

// File: rtl/rom_byte_streamer.sv
// Purpose: reads a run of words from a 1-cycle-latency ROM and emits them as a byte stream.
// Latency: start edge E0 -> rom_rd_en E0..E1 -> first out_valid from E2; 2 idle cycles between words.
// Backpressure: valid/ready on the byte stream; byte and last hold while out_ready is low.
//
// Ports:
//   clk, rst_b        clock, asynchronous active-low reset
//   start             begin a transfer (looked at in IDLE only)
//   base_addr         first ROM word address, latched on start
//   word_count        number of words, latched on start (0 = just pulse done)
//   busy, done        busy outside IDLE; done pulses for one cycle at the end
//   bus (master)      ROM read port (rom_rd_en/rom_addr/rom_data) and byte
//                     stream (out_data/out_valid/out_ready/out_last)
module rom_byte_streamer #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 3,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  rom_byte_streamer_if.master   bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [ADDR_WIDTH:0] ONE_WORD = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;       // address of the word being processed
  logic [ADDR_WIDTH:0]   r_remaining;  // words left, including the current one
  logic [DATA_WIDTH-1:0] r_shift;      // captured ROM word
  logic [IDX_W-1:0]      r_idx;        // position of the current byte in emit order
  logic                  r_rom_rd_en;
  logic [ADDR_WIDTH-1:0] r_rom_addr;

  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [ADDR_WIDTH:0]   w_rem_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic                  w_load;
  logic [IDX_W-1:0]      w_sel;
  logic [7:0]            w_bytes [BYTES];

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_rem_nxt   = r_remaining;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            w_addr_nxt  = base_addr;
            w_rem_nxt   = word_count;
            w_state_nxt = S_READ;
          end else begin
            // empty transfer: report completion without touching the ROM
            w_state_nxt = S_FINISH;
          end
        end
      end

      S_READ: begin
        w_state_nxt = S_CAPTURE;
      end

      S_CAPTURE: begin
        // ROM data_out became valid at the edge that closed READ
        w_load      = 1'b1;
        w_idx_nxt   = '0;
        w_state_nxt = S_DRAIN;
      end

      S_DRAIN: begin
        if (bus.out_ready) begin
          if (r_idx == LAST_IDX) begin
            w_idx_nxt = '0;
            if (r_remaining != ONE_WORD) begin
              // address wraps naturally at 2^ADDR_WIDTH
              w_addr_nxt  = r_addr + 1'b1;
              w_rem_nxt   = r_remaining - 1'b1;
              w_state_nxt = S_READ;
            end else begin
              w_rem_nxt   = '0;
              w_state_nxt = S_FINISH;
            end
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end

      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_shift     <= '0;
      r_idx       <= '0;
      r_rom_rd_en <= 1'b0;
      r_rom_addr  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_remaining <= w_rem_nxt;
      r_idx       <= w_idx_nxt;
      if (w_load) begin
        r_shift <= bus.rom_data;
      end
      // Read port is registered from the next state so the ROM sees
      // rd_en/addr during the whole READ cycle.
      r_rom_rd_en <= (w_state_nxt == S_READ);
      if (w_state_nxt == S_READ) begin
        r_rom_addr <= w_addr_nxt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Byte selection: index counts in emit order, mapped to a physical lane
  // ---------------------------------------------------------------------------
  for (genvar b = 0; b < BYTES; b++) begin : g_bytes
    assign w_bytes[b] = r_shift[8*b +: 8];
  end

  assign w_sel = LITTLE_ENDIAN ? r_idx : (LAST_IDX - r_idx);

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_FINISH);
  assign bus.rom_rd_en = r_rom_rd_en;
  assign bus.rom_addr  = r_rom_addr;
  assign bus.out_valid = (r_state == S_DRAIN);
  assign bus.out_data  = w_bytes[w_sel];
  assign bus.out_last  = (r_state == S_DRAIN) && (r_remaining == ONE_WORD) &&
                         (r_idx == LAST_IDX);

endmodule
